mul_4bit_shift_add: RTL and testbench

- Sequential unsigned shift-add multiplier. It is the multiply-side companion of the team's sequential restoring divider, sharing the same start/FSM style.
- Captures two N-bit operands on `start`, computes one partial product per cycle, and presents a registered 2N-bit product with a done flag.
- Sits beside the divider in the FPGA mul/div datapath, driven by the same top-level controller.

---
 rtl/mul_4bit_shift_add_if.sv | 14 +
 rtl/mul_4bit_shift_add.sv | 105 ++++++++++
 tb/tb_mul_4bit_shift_add.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mul_4bit_shift_add_if.sv
// Start/operand/result bundle between the mul/div controller and the shift-add multiplier.
interface mul_4bit_shift_add_if #(
    parameter int unsigned N = 4
);
    logic             start;
    logic [N-1:0]     operA;
    logic [N-1:0]     operB;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             done;

    modport master (output start, operA, operB, input product, busy, done);
    modport slave  (input start, operA, operB, output product, busy, done);
endinterface

// File: rtl/mul_4bit_shift_add.sv
// Sequential unsigned shift-add multiplier: one partial product per cycle, registered 2N-bit result.
// Optional macro ZERO_BYPASS_EN: a zero operand skips CALC and completes one edge after acceptance.
module mul_4bit_shift_add #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_4bit_shift_add_if.slave  bus
);
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned PW = 2 * N;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state,   w_state_n;
    logic [N-1:0]    r_a,       w_a_n;
    logic [N:0]      r_acc,     w_acc_n;
    logic [N-1:0]    r_q,       w_q_n;
    logic [CW-1:0]   r_cnt,     w_cnt_n;
    logic [PW-1:0]   r_product, w_product_n;
    logic            r_busy,    r_done;

    logic [N:0]      w_addend;
    logic [N:0]      w_sum;
    logic [PW:0]     w_shift;

    // One shift-add step; the N+1-bit sum cannot overflow since acc < 2^N after every shift.
    assign w_addend = r_q[0] ? {1'b0, r_a} : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_shift  = {w_sum, r_q} >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_a       <= w_a_n;
            r_acc     <= w_acc_n;
            r_q       <= w_q_n;
            r_cnt     <= w_cnt_n;
            r_product <= w_product_n;
            r_busy    <= (w_state_n == S_CALC);
            r_done    <= (w_state_n == S_DONE);
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_a_n       = r_a;
        w_acc_n     = r_acc;
        w_q_n       = r_q;
        w_cnt_n     = r_cnt;
        w_product_n = r_product;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef ZERO_BYPASS_EN
                    if ((bus.operA == '0) || (bus.operB == '0)) begin
                        w_product_n = '0;
                        w_state_n   = S_DONE;
                    end else begin
                        w_a_n     = bus.operA;
                        w_q_n     = bus.operB;
                        w_acc_n   = '0;
                        w_cnt_n   = CW'(N - 1);
                        w_state_n = S_CALC;
                    end
`else
                    w_a_n     = bus.operA;
                    w_q_n     = bus.operB;
                    w_acc_n   = '0;
                    w_cnt_n   = CW'(N - 1);
                    w_state_n = S_CALC;
`endif
                end
            end
            S_CALC: begin
                w_acc_n = w_shift[PW:N];
                w_q_n   = w_shift[N-1:0];
                w_cnt_n = r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    w_product_n = w_shift[PW-1:0];
                    w_state_n   = S_DONE;
                end
            end
            S_DONE: begin
                // Holding start keeps us here so a long start level yields only one result.
                if (!bus.start) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign bus.product = r_product;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_mul_4bit_shift_add.sv
// Directed bench for mul_4bit_shift_add: N=4 and N=8 instances, hand-computed products and latencies.
module tb_mul_4bit_shift_add;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mul_4bit_shift_add_if #(.N(4)) b4 ();
    mul_4bit_shift_add_if #(.N(8)) b8 ();

    mul_4bit_shift_add #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mul_4bit_shift_add #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ZERO_BYPASS_EN
    localparam int ZERO_EDGES = 1;
    localparam int ZERO_BUSY  = 0;
`else
    localparam int ZERO_EDGES = 5;
    localparam int ZERO_BUSY  = 4;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (sel == 8) begin
            b8.start = s; b8.operA = a;      b8.operB = b;
        end else begin
            b4.start = s; b4.operA = a[3:0]; b4.operB = b[3:0];
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 8) ? b8.done : b4.done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 8) ? b8.busy : b4.busy;
    endfunction

    function automatic logic [31:0] get_prod(input int sel);
        return (sel == 8) ? 32'(b8.product) : 32'(b4.product);
    endfunction

    // Pulse start for one edge; count edges (acceptance edge = 1) until done, and busy cycles.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         output int edges, output int nbusy);
        edges = 0;
        nbusy = 0;
        drive(sel, 1'b1, a, b);
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) drive(sel, 1'b0, a, b);
            if (get_busy(sel)) nbusy++;
        end while (!get_done(sel) && edges < 40);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        int edges;
        int nbusy;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive(4, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 8'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", get_prod(4), 32'd0);
        check("rst_busy",    32'(b4.busy), 32'd0);
        check("rst_done",    32'(b4.done), 32'd0);
        rst = 1'b0;
        idle_cycle();

        // 13*11 single-cycle start
        do_op(4, 8'd13, 8'd11, edges, nbusy);
        check("13x11_product", get_prod(4), 32'd143);
        check("13x11_edges",   32'(edges), 32'd5);
        check("13x11_busy",    32'(nbusy), 32'd4);
        idle_cycle();
        check("13x11_idle_done", 32'(b4.done), 32'd0);

        // 15*15 with start held: stays in DONE until start drops
        drive(4, 1'b1, 8'd15, 8'd15);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!b4.done && edges < 40);
        check("15x15_edges", 32'(edges), 32'd5);
        check("15x15_product", get_prod(4), 32'd225);
        repeat (3) idle_cycle();
        check("15x15_hold_done", 32'(b4.done), 32'd1);
        check("15x15_hold_busy", 32'(b4.busy), 32'd0);
        check("15x15_hold_product", get_prod(4), 32'd225);
        drive(4, 1'b0, 8'd15, 8'd15);
        idle_cycle();
        check("15x15_release_done", 32'(b4.done), 32'd0);
        check("15x15_release_busy", 32'(b4.busy), 32'd0);
        do_op(4, 8'd3, 8'd5, edges, nbusy);
        check("3x5_product", get_prod(4), 32'd15);
        check("3x5_edges",   32'(edges), 32'd5);
        idle_cycle();

        // zero operand: bypass timing depends on the build
        do_op(4, 8'd0, 8'd9, edges, nbusy);
        check("0x9_product", get_prod(4), 32'd0);
        check("0x9_edges",   32'(edges), 32'(ZERO_EDGES));
        check("0x9_busy",    32'(nbusy), 32'(ZERO_BUSY));
        idle_cycle();

        // 7*6 with start toggling and operands changing during CALC
        drive(4, 1'b1, 8'd7, 8'd6);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) drive(4, 1'b0, 8'd2, 8'd2);
            if (edges == 2) drive(4, 1'b1, 8'd2, 8'd2);
            if (edges == 3) drive(4, 1'b0, 8'd2, 8'd2);
        end while (!b4.done && edges < 40);
        check("7x6_product", get_prod(4), 32'd42);
        check("7x6_edges",   32'(edges), 32'd5);
        idle_cycle();

        // 9*9 aborted by reset two edges in
        drive(4, 1'b1, 8'd9, 8'd9);
        @(posedge clk); #1;
        drive(4, 1'b0, 8'd9, 8'd9);
        check("9x9_busy_before_rst", 32'(b4.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_product", get_prod(4), 32'd0);
        check("abort_busy",    32'(b4.busy), 32'd0);
        check("abort_done",    32'(b4.done), 32'd0);
        repeat (5) idle_cycle();
        check("abort_stays_idle", 32'(b4.done), 32'd0);
        do_op(4, 8'd9, 8'd9, edges, nbusy);
        check("9x9_product", get_prod(4), 32'd81);
        check("9x9_edges",   32'(edges), 32'd5);
        idle_cycle();

        // N=8 instance
        do_op(8, 8'd255, 8'd255, edges, nbusy);
        check("n8_255x255_product", get_prod(8), 32'd65025);
        check("n8_255x255_edges",   32'(edges), 32'd9);
        check("n8_255x255_busy",    32'(nbusy), 32'd8);
        idle_cycle();
        do_op(8, 8'd1, 8'd200, edges, nbusy);
        check("n8_1x200_product", get_prod(8), 32'd200);
        check("n8_1x200_edges",   32'(edges), 32'd9);
        check("n4_untouched_product", get_prod(4), 32'd81);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
